// File: rtl/fpu_mul_param.sv
// fpu_mul_param
// ---------------------------------------------------------------------------
// Parametrised IEEE-754 binary floating-point multiplier for the CPU FPU.
// It has configurable exponent and mantissa widths, the five RISC-V rounding
// modes and accrued exception flags. Normalisation is done in a single cycle,
// so the latency does not depend on the data.
//
// Ports
//   i_clock    : clock, rising edge
//   i_reset    : synchronous, active-high reset
//   i_request  : operation request (level, held until o_ready is seen)
//   i_rm       : rounding mode 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM (5..7 -> RNE)
//   i_op1      : multiplicand, W = 1+EXP_W+MAN_W bits
//   i_op2      : multiplier
//   o_ready    : result valid
//   o_result   : product
//   o_flags    : {NV, DZ, OF, UF, NX}; DZ is always 0
//   o_state    : FSM state, for debug and checker binding
//
// Handshake: i_request is sampled only in IDLE, where it captures both
// operands and i_rm. The request must then stay high. o_ready rises together
// with o_result/o_flags (1 cycle later for special operands, 5 cycles later
// for all others). It stays high while i_request stays high. The first edge
// that samples i_request=0 drops o_ready and returns to IDLE. A new request
// therefore needs i_request low for at least one cycle. o_result and o_flags
// hold their values until the next result or a reset.
// ---------------------------------------------------------------------------
module fpu_mul_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_request,
    input  logic [2:0]           i_rm,
    input  logic [EXP_W+MAN_W:0] i_op1,
    input  logic [EXP_W+MAN_W:0] i_op2,
    output logic                 o_ready,
    output logic [EXP_W+MAN_W:0] o_result,
    output logic [4:0]           o_flags,
    output logic [2:0]           o_state
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 3;      // signed internal exponent
    localparam int MW = MAN_W + 1;      // mantissa with hidden bit
    localparam int PW = 2 * MW;         // full product
    localparam int XW = MW + 2;         // mantissa + guard + round

    localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] ONE   = EW'(1);
    localparam logic signed [EW-1:0] E_MIN = ONE - BIAS;

    localparam logic [W-1:0]   QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-2:0]   MAG_INF = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
    localparam logic [W-2:0]   MAG_MAX = {{(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CLASSIFY = 3'd1;
    localparam logic [2:0] S_NORM     = 3'd2;
    localparam logic [2:0] S_MULT     = 3'd3;
    localparam logic [2:0] S_ALIGN    = 3'd4;
    localparam logic [2:0] S_ROUND    = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    logic [2:0]           state;
    logic [W-1:0]         op_a, op_b;
    logic [2:0]           rm_q;
    logic                 a_s, b_s;
    logic signed [EW-1:0] a_e, b_e;
    logic [MW-1:0]        a_m, b_m;
    logic                 z_s;
    logic signed [EW-1:0] z_e;
    logic [PW-1:0]        prod;
    logic [MW-1:0]        z_m;
    logic                 grd, rnd, stk, tiny;

    assign o_state = state;

    // ---------------- unpack and classify the captured operands -----------
    logic [EXP_W-1:0]     a_ef, b_ef;
    logic [MAN_W-1:0]     a_ff, b_ff;
    logic                 a_nan, b_nan, a_snan, b_snan;
    logic                 a_inf, b_inf, a_zero, b_zero;
    logic signed [EW-1:0] a_ue, b_ue;
    logic [MW-1:0]        a_um, b_um;

    assign a_ef   = op_a[W-2:MAN_W];
    assign b_ef   = op_b[W-2:MAN_W];
    assign a_ff   = op_a[MAN_W-1:0];
    assign b_ff   = op_b[MAN_W-1:0];
    assign a_nan  = (&a_ef) & (|a_ff);
    assign b_nan  = (&b_ef) & (|b_ff);
    assign a_snan = a_nan & ~a_ff[MAN_W-1];
    assign b_snan = b_nan & ~b_ff[MAN_W-1];
    assign a_inf  = (&a_ef) & ~(|a_ff);
    assign b_inf  = (&b_ef) & ~(|b_ff);
    assign a_zero = ~(|a_ef) & ~(|a_ff);
    assign b_zero = ~(|b_ef) & ~(|b_ff);

    // Subnormals use exponent 1-BIAS with no hidden bit.
    assign a_ue = (a_ef == '0) ? E_MIN : $signed({3'b000, a_ef}) - BIAS;
    assign b_ue = (b_ef == '0) ? E_MIN : $signed({3'b000, b_ef}) - BIAS;
    assign a_um = {|a_ef, a_ff};
    assign b_um = {|b_ef, b_ff};

    logic         sp_valid;
    logic [W-1:0] sp_result;
    logic [4:0]   sp_flags;
    logic         sp_sign;
    logic         sp_invalid;

    always_comb begin
        sp_sign    = op_a[W-1] ^ op_b[W-1];
        sp_invalid = (a_inf & b_zero) | (a_zero & b_inf);
        sp_valid   = 1'b1;
        sp_result  = '0;
        sp_flags   = '0;
        if (a_nan | b_nan | sp_invalid) begin
            sp_result   = QNAN;
            sp_flags[4] = sp_invalid | a_snan | b_snan;
        end else if (a_inf | b_inf) begin
            sp_result = {sp_sign, MAG_INF};
        end else if (a_zero | b_zero) begin
            sp_result = {sp_sign, {(W-1){1'b0}}};
        end else begin
            sp_valid = 1'b0;
        end
    end

    // ---------------- normalise: leading-zero count of each mantissa ------
    function automatic int lzc(input logic [MW-1:0] m);
        int   n;
        logic found;
        n     = 0;
        found = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (m[i]) found = 1'b1;
            else if (!found) n = n + 1;
        end
        return n;
    endfunction

    int a_lz, b_lz;
    assign a_lz = lzc(a_m);
    assign b_lz = lzc(b_m);

    // ---------------- align: 1-bit normalise, then denormalise if tiny ----
    logic [PW-1:0]        al_p;
    logic signed [EW-1:0] al_e0, al_e;
    logic [MW-1:0]        al_m;
    logic                 al_g, al_r, al_s, al_tiny;
    logic [2*XW-1:0]      al_ext;

    always_comb begin
        int diff_i;
        int sh_i;
        // The product value lies in [1,4), so at most one leading zero.
        al_p    = prod[PW-1] ? prod : (prod << 1);
        al_e0   = prod[PW-1] ? z_e : (z_e - ONE);
        al_m    = al_p[PW-1 -: MW];
        al_g    = al_p[MW-1];
        al_r    = al_p[MW-2];
        al_s    = |al_p[MW-3:0];
        al_e    = al_e0;
        al_tiny = 1'b0;
        al_ext  = '0;
        diff_i  = 0;
        sh_i    = 0;
        if (al_e0 < E_MIN) begin
            // Shift {m,g,r} right in one step; shift amount saturates once
            // every bit has moved into sticky.
            diff_i  = int'(E_MIN) - int'(al_e0);
            sh_i    = (diff_i > XW) ? XW : diff_i;
            al_ext  = {al_m, al_g, al_r, {XW{1'b0}}} >> sh_i;
            al_m    = al_ext[2*XW-1 -: MW];
            al_g    = al_ext[XW+1];
            al_r    = al_ext[XW];
            al_s    = al_s | (|al_ext[XW-1:0]);
            al_e    = E_MIN;
            al_tiny = 1'b1;
        end
    end

    // ---------------- round and pack -------------------------------------
    logic                 rd_any, rd_inc, rd_of;
    logic [MW:0]          rd_sum;
    logic [MW-1:0]        rd_m;
    logic signed [EW-1:0] rd_e, rd_eb;
    logic [W-1:0]         rd_result;
    logic [4:0]           rd_flags;

    always_comb begin
        rd_any = grd | rnd | stk;
        case (rm_q)
            3'd1:    rd_inc = 1'b0;
            3'd2:    rd_inc = z_s & rd_any;
            3'd3:    rd_inc = ~z_s & rd_any;
            3'd4:    rd_inc = grd;
            default: rd_inc = grd & (rnd | stk | z_m[0]);
        endcase
        rd_sum = {1'b0, z_m} + {{MW{1'b0}}, rd_inc};
        if (rd_sum[MW]) begin
            rd_m = rd_sum[MW:1];
            rd_e = z_e + ONE;
        end else begin
            // A subnormal that rounds into the hidden bit becomes the minimum
            // normal: the exponent is already 1-BIAS, so the biased field is 1.
            rd_m = rd_sum[MW-1:0];
            rd_e = z_e;
        end
        rd_of    = rd_e > BIAS;
        rd_eb    = rd_e + BIAS;
        rd_flags = {2'b00, rd_of, tiny & rd_any, rd_any | rd_of};
        if (rd_of) begin
            case (rm_q)
                3'd1:    rd_result = {z_s, MAG_MAX};
                3'd2:    rd_result = z_s ? {1'b1, MAG_INF} : {1'b0, MAG_MAX};
                3'd3:    rd_result = z_s ? {1'b1, MAG_MAX} : {1'b0, MAG_INF};
                default: rd_result = {z_s, MAG_INF};
            endcase
        end else begin
            rd_result = {z_s, (rd_m[MW-1] ? rd_eb[EXP_W-1:0] : {EXP_W{1'b0}}),
                         rd_m[MAN_W-1:0]};
        end
    end

    // ---------------- control FSM and datapath registers -----------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state    <= S_IDLE;
            o_ready  <= 1'b0;
            o_result <= '0;
            o_flags  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_request) begin
                        op_a  <= i_op1;
                        op_b  <= i_op2;
                        rm_q  <= i_rm;
                        state <= S_CLASSIFY;
                    end
                end
                S_CLASSIFY: begin
                    a_s <= op_a[W-1];
                    b_s <= op_b[W-1];
                    a_e <= a_ue;
                    b_e <= b_ue;
                    a_m <= a_um;
                    b_m <= b_um;
                    if (sp_valid) begin
                        o_result <= sp_result;
                        o_flags  <= sp_flags;
                        o_ready  <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        state <= S_NORM;
                    end
                end
                S_NORM: begin
                    a_m   <= a_m << a_lz;
                    b_m   <= b_m << b_lz;
                    a_e   <= a_e - $signed(EW'(a_lz));
                    b_e   <= b_e - $signed(EW'(b_lz));
                    state <= S_MULT;
                end
                S_MULT: begin
                    // The product MSB carries weight 2^(a_e+b_e+1).
                    z_s   <= a_s ^ b_s;
                    z_e   <= a_e + b_e + ONE;
                    prod  <= PW'(a_m) * PW'(b_m);
                    state <= S_ALIGN;
                end
                S_ALIGN: begin
                    z_m   <= al_m;
                    grd   <= al_g;
                    rnd   <= al_r;
                    stk   <= al_s;
                    z_e   <= al_e;
                    tiny  <= al_tiny;
                    state <= S_ROUND;
                end
                S_ROUND: begin
                    o_result <= rd_result;
                    o_flags  <= rd_flags;
                    o_ready  <= 1'b1;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    if (!i_request) begin
                        o_ready <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_mul_param.sv
module tb_fpu_mul_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // single-precision DUT
  logic        req32;
  logic [2:0]  rm32;
  logic [31:0] a32, b32, res32;
  logic        rdy32;
  logic [4:0]  fl32;
  logic [2:0]  st32;

  // double-precision DUT
  logic        req64;
  logic [2:0]  rm64;
  logic [63:0] a64, b64, res64;
  logic        rdy64;
  logic [4:0]  fl64;
  logic [2:0]  st64;

  fpu_mul_param #(.EXP_W(8), .MAN_W(23)) dut32 (
    .i_clock(clk), .i_reset(rst), .i_request(req32), .i_rm(rm32),
    .i_op1(a32), .i_op2(b32), .o_ready(rdy32), .o_result(res32),
    .o_flags(fl32), .o_state(st32)
  );

  fpu_mul_param #(.EXP_W(11), .MAN_W(52)) dut64 (
    .i_clock(clk), .i_reset(rst), .i_request(req64), .i_rm(rm64),
    .i_op1(a64), .i_op2(b64), .o_ready(rdy64), .o_result(res64),
    .o_flags(fl64), .o_state(st64)
  );

  // ---------------- scoreboard ----------------
  logic [68:0] exp_q[$];   // {result (zero-extended to 64), flags}
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- driver ----------------
  // Issues one request, waits for o_ready, compares latency and the popped
  // expectation, then drops the request and checks o_ready falls.
  task automatic run_op(input bit wide, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] rm, input logic [63:0] res,
                        input logic [4:0] flags, input int lat, input string name);
    int          k;
    logic        got;
    logic [68:0] exp_v, act_v;
    @(negedge clk);
    if (wide) begin a64 = a; b64 = b; rm64 = rm; req64 = 1'b1; end
    else begin a32 = a[31:0]; b32 = b[31:0]; rm32 = rm; req32 = 1'b1; end
    exp_q.push_back({res, flags});
    @(posedge clk);                    // capture edge
    k   = 0;
    got = 1'b0;
    while (!got && k < 20) begin
      @(posedge clk); #1;
      k++;
      got = wide ? rdy64 : rdy32;
    end
    check({name, ":ready"}, 69'(got), 69'(1));
    check({name, ":latency"}, 69'(k), 69'(lat));
    exp_v = exp_q.pop_front();
    act_v = wide ? {res64, fl64} : {32'h0, res32, fl32};
    check({name, ":result"}, act_v, exp_v);
    @(negedge clk);
    if (wide) req64 = 1'b0; else req32 = 1'b0;
    @(posedge clk); #1;
    check({name, ":drop"}, 69'(wide ? rdy64 : rdy32), 69'(0));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm;
    logic [31:0] res;
    logic [4:0]  flags;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_res;
    int          k;
    logic        got;
    logic [68:0] exp_v;

    vecs.push_back('{32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 5'h00, 5}); // 1.5*2
    vecs.push_back('{32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 5'h10, 1}); // inf*0
    vecs.push_back('{32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 5'h10, 1}); // sNaN
    vecs.push_back('{32'h7FC00001, 32'h3F800000, 3'd0, 32'h7FC00000, 5'h00, 1}); // qNaN
    vecs.push_back('{32'h7F800000, 32'hC0000000, 3'd0, 32'hFF800000, 5'h00, 1}); // inf*-2
    vecs.push_back('{32'h80000000, 32'h40400000, 3'd0, 32'h80000000, 5'h00, 1}); // -0*3
    vecs.push_back('{32'h7F7FFFFF, 32'h40000000, 3'd0, 32'h7F800000, 5'h05, 5}); // OF RNE
    vecs.push_back('{32'h7F7FFFFF, 32'h40000000, 3'd1, 32'h7F7FFFFF, 5'h05, 5}); // OF RTZ
    vecs.push_back('{32'hFF7FFFFF, 32'h40000000, 3'd3, 32'hFF7FFFFF, 5'h05, 5}); // -OF RUP
    vecs.push_back('{32'hFF7FFFFF, 32'h40000000, 3'd2, 32'hFF800000, 5'h05, 5}); // -OF RDN
    vecs.push_back('{32'h00800000, 32'h3F000000, 3'd0, 32'h00400000, 5'h00, 5}); // exact subnormal
    vecs.push_back('{32'h00000001, 32'h3F000000, 3'd0, 32'h00000000, 5'h03, 5}); // UF RNE
    vecs.push_back('{32'h00000001, 32'h3F000000, 3'd3, 32'h00000001, 5'h03, 5}); // UF RUP
    vecs.push_back('{32'h007FFFFF, 32'h3F800001, 3'd0, 32'h00800000, 5'h03, 5}); // round to min normal
    vecs.push_back('{32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 5'h01, 5}); // sticky only, RNE
    vecs.push_back('{32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 5'h01, 5}); // sticky, RUP
    vecs.push_back('{32'hBF800001, 32'h3F800001, 3'd2, 32'hBF800003, 5'h01, 5}); // negative RDN
    vecs.push_back('{32'h3F800002, 32'h3FA00000, 3'd0, 32'h3FA00002, 5'h01, 5}); // tie, even lsb
    vecs.push_back('{32'h3F800002, 32'h3FA00000, 3'd4, 32'h3FA00003, 5'h01, 5}); // tie, RMM
    vecs.push_back('{32'h3F800002, 32'h3FA00000, 3'd7, 32'h3FA00002, 5'h01, 5}); // rm 7 -> RNE
    vecs.push_back('{32'h3F800001, 32'h3FFFFFFE, 3'd0, 32'h40000000, 5'h01, 5}); // carry-out
    vecs.push_back('{32'h3F800001, 32'h3FFFFFFE, 3'd1, 32'h3FFFFFFF, 5'h01, 5}); // RTZ truncates

    // reset values
    rst = 1'b1;
    req32 = 1'b0; rm32 = 3'd0; a32 = '0; b32 = '0;
    req64 = 1'b0; rm64 = 3'd0; a64 = '0; b64 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset32", {32'h0, res32, fl32, rdy32, st32}, 69'(0));
    check("reset64", {res64, fl64}, 69'(0));
    check("reset64_ready", 69'(rdy64), 69'(0));
    @(negedge clk);
    rst = 1'b0;

    // table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(1'b0, {32'h0, vecs[i].a}, {32'h0, vecs[i].b}, vecs[i].rm,
             {32'h0, vecs[i].res}, vecs[i].flags, vecs[i].lat,
             $sformatf("vec%0d", i));
    end

    // handshake: hold request 5 cycles past ready; late operand changes ignored
    @(negedge clk);
    a32 = 32'h3FC00000; b32 = 32'h40000000; rm32 = 3'd0; req32 = 1'b1;
    exp_q.push_back({32'h0, 32'h40400000, 5'h00});
    @(posedge clk);
    @(negedge clk);
    a32 = 32'hDEADBEEF; b32 = 32'h7F800000; rm32 = 3'd3;
    k = 1; got = 1'b0;
    @(posedge clk); #1;
    got = rdy32;
    while (!got && k < 20) begin
      @(posedge clk); #1;
      k++;
      got = rdy32;
    end
    check("hold:latency", 69'(k), 69'(5));
    exp_v = exp_q.pop_front();
    check("hold:result", {32'h0, res32, fl32}, exp_v);
    hold_res = res32;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("hold:stable%0d", c), {32'h0, res32, fl32, rdy32, st32},
            {32'h0, 32'h40400000, 5'h00, 1'b1, 3'd6});
    end
    @(negedge clk);
    req32 = 1'b0;
    @(posedge clk); #1;
    check("hold:drop", {32'h0, res32, fl32, rdy32}, {33'h0, hold_res, 5'h00, 1'b0});

    // reset while in MULT clears outputs; a fresh request then completes
    @(negedge clk);
    a32 = 32'h3FC00000; b32 = 32'h40000000; rm32 = 3'd0; req32 = 1'b1;
    @(posedge clk);               // capture
    @(posedge clk);               // CLASSIFY -> NORM
    @(posedge clk); #1;           // NORM -> MULT
    check("rst:in_mult", 69'(st32), 69'(3));
    @(negedge clk);
    rst = 1'b1;
    req32 = 1'b0;
    @(posedge clk); #1;
    check("rst:outputs", {32'h0, res32, fl32, rdy32, st32}, 69'(0));
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 64'h3F800001, 64'h3F800001, 3'd3, 64'h3F800003, 5'h01, 5, "after_rst");

    // double precision
    run_op(1'b1, 64'h3FF8000000000000, 64'h4000000000000000, 3'd0,
           64'h4008000000000000, 5'h00, 5, "dp_normal");
    run_op(1'b1, 64'hFFF0000000000000, 64'h0000000000000000, 3'd0,
           64'h7FF8000000000000, 5'h10, 1, "dp_invalid");
    run_op(1'b1, 64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 3'd1,
           64'h7FEFFFFFFFFFFFFF, 5'h05, 5, "dp_overflow_rtz");

    check("scoreboard_empty", 69'(exp_q.size()), 69'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fpu_mul_param.md
# fpu_mul_param

- Parametrised IEEE-754 binary floating-point multiplier for the CPU FPU. It replaces the fixed single-precision multiplier.
- Adds:
  - configurable exponent and mantissa widths;
  - all five RISC-V rounding modes;
  - accrued exception flags;
  - single-cycle normalisation, which gives a fixed, data-independent latency.
- Sits behind the FPU execute stage and uses the same request/ready handshake as the other FPU units.

## Interface
- `EXP_W`, default 8: exponent field width. BIAS = 2^(EXP_W-1)-1.
- `MAN_W`, default 23: stored fraction width. W = 1+EXP_W+MAN_W.
- `i_clock` in 1: clock, rising edge.
- `i_reset` in 1: reset, synchronous, active-high.
- `i_request` in 1: operation request, level, held until the operation completes.
- `i_rm` in 3: rounding mode. 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM. Codes 5–7 are treated as RNE.
- `i_op1` in W: multiplicand.
- `i_op2` in W: multiplier.
- `o_ready` out 1: result valid.
- `o_result` out W: product.
- `o_flags` out 5: {NV, DZ, OF, UF, NX}. DZ is always 0.

## Operation
- **Capture:** in IDLE with `i_request`=1, register both operands and `i_rm`.
- **Unpack:** sign, biased exponent and fraction for each operand.
- **Internal exponent:** signed, EXP_W+3 bits, unbiased.
- **Subnormals:** exponent taken as 1-BIAS, no hidden bit.
- **Product width:** 2*(MAN_W+1) bits.

CLASSIFY state, evaluated in priority order:
1. Either operand is a NaN, or inf×0 → canonical quiet NaN: sign 0, exponent all-ones, fraction MSB 1, rest 0. NV is set if inf×0 or if either operand is a signalling NaN (fraction MSB 0, fraction ≠0).
2. Either operand is inf → inf, sign a_s^b_s.
3. Either operand is zero → zero, sign a_s^b_s.
4. Otherwise → NORM.

Special results set `o_ready` and go to DONE.

Regular path states:
- **NORM:** a priority encoder left-shifts each mantissa until its hidden bit is set, in one cycle. Each exponent is decremented by its shift count.
- **MULT:** z_s = a_s^b_s; z_e = a_e+b_e+1; form the product.
- **ALIGN:**
  - Normalise the product MSB by at most a 1-bit left shift, decrementing z_e.
  - Take the top MAN_W+1 bits as z_m, plus guard, round and sticky (OR of the remainder).
  - If z_e < 1-BIAS: right-shift by (1-BIAS)-z_e, saturated at MAN_W+3, in one cycle. Shifted-out bits OR into sticky; z_e = 1-BIAS; set `tiny`.
- **ROUND:** increment decision per `i_rm`, with lsb = z_m[0] and G/R/S.
  - RNE: G&(R|S|lsb).
  - RTZ: never.
  - RDN: z_s&(G|R|S).
  - RUP: !z_s&(G|R|S).
  - RMM: G.
  - Mantissa carry-out: shift right 1, z_e+1.
  - Subnormal rounding up to the hidden bit becomes the minimum normal.
- **PACK:**
  - Inexact = G|R|S. NX = inexact.
  - UF = tiny & inexact.
  - Exponent field is 0 if the hidden bit is 0 after rounding.
  - Overflow (z_e > BIAS): set OF and NX. The result is:
    - RNE/RMM → ±inf.
    - RTZ → ±max finite.
    - RDN → +max / −inf.
    - RUP → +inf / −max.

## Timing
- **Reset values:** `o_ready`=0, `o_result`=0, `o_flags`=0, state IDLE.
- **Latency,** counting the edge on which IDLE samples `i_request`=1 as edge N:
  - Special operands: `o_ready`=1 after edge N+1.
  - All other operands: `o_ready`=1 after edge N+5. States: CLASSIFY N+1, NORM N+2, MULT N+3, ALIGN N+4, ROUND N+5, PACK writes result.
- `o_result` and `o_flags` are updated on the same edge that raises `o_ready`, and are held stable until the next result.
- **DONE:** `o_ready` stays 1 while `i_request`=1. The edge that samples `i_request`=0 clears `o_ready` and returns to IDLE.
- There is no back-to-back issue without dropping `i_request` for at least one cycle.
- Operand or `i_rm` changes after the capture edge are ignored.
- **Reset mid-operation:** `i_reset` in any state goes to IDLE with `o_ready`=0 on that edge. `o_result`/`o_flags` are cleared. The next request is processed normally. Reset has priority over every state action.

## Test plan
All values FP32 defaults unless noted.
1. **Normal product:** 0x3FC00000 × 0x40000000, rm=0 → 0x40400000, flags 0x00, `o_ready` high exactly 5 cycles after the capture edge.
2. **Invalid and signalling NaN:**
   - 0x7F800000 × 0x00000000 → 0x7FC00000, flags 0x10, ready after 1 cycle.
   - 0x7F800001 × 0x3F800000 → 0x7FC00000, flags 0x10.
   - 0x7FC00001 × 0x3F800000 → 0x7FC00000, flags 0x00.
3. **Overflow, operands 0x7F7FFFFF × 0x40000000:**
   - rm=0 → 0x7F800000, flags 0x05.
   - rm=1 → 0x7F7FFFFF, flags 0x05.
   - Same magnitude, negative sign, rm=3 → 0xFF7FFFFF.
4. **Subnormal/underflow:**
   - 0x00800000 × 0x3F000000 → 0x00400000, flags 0x00.
   - 0x00000001 × 0x3F000000, rm=0 → 0x00000000, flags 0x03.
   - Same operands, rm=3 → 0x00000001, flags 0x03.
5. **Handshake and reset:**
   - Hold `i_request` 5 cycles past ready → `o_ready` and result stable. Drop it → `o_ready`=0 next edge.
   - Assert `i_reset` during MULT → `o_ready`=0, outputs 0. A new request then completes correctly.
6. **Double precision:** EXP_W=11, MAN_W=52. 0x3FF8000000000000 × 0x4000000000000000 → 0x4008000000000000, flags 0.
